// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC auto-claim sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package plic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAIM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Ring pointers carry one extra wrap bit so full and empty differ.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/plic_id_ring.sv
// In-order store of claimed IDs with write, deliver and complete pointers.
// Latency: a pushed ID is visible on dlv_id_o the cycle after push_i.
// Backpressure: dlv side is valid/ready; dlv_id_o holds until accepted.
// Ports: push_i/push_id_i write a claimed ID; dlv_* deliver the oldest
//        undelivered ID; cmp_pop_i retires the oldest delivered ID and
//        cmp_id_o shows it; outstanding_o = pushed minus retired.
module plic_id_ring
    import plic_pkg::*;
#(
    parameter int  SRCW  = 5,
    parameter int  DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [SRCW-1:0]  push_id_i,
    output logic             dlv_vld_o,
    output logic [SRCW-1:0]  dlv_id_o,
    input  logic             dlv_rdy_i,
    output logic             cmp_vld_o,
    output logic [SRCW-1:0]  cmp_id_o,
    input  logic             cmp_pop_i,
    output logic [PTR_W-1:0] outstanding_o
);

    localparam int IDX_W = PTR_W - 1;

    logic [SRCW-1:0]  ring_q [DEPTH];
    logic [SRCW-1:0]  ring_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] dlv_q, dlv_d;
    logic [PTR_W-1:0] cmp_q, cmp_d;
    logic             push_ok;
    logic             dlv_fire;
    logic             cmp_fire;

    assign outstanding_o = wr_q - cmp_q;
    assign dlv_vld_o     = (dlv_q != wr_q);
    assign dlv_id_o      = ring_q[dlv_q[IDX_W-1:0]];
    // Entries between cmp and dlv are accepted by the consumer but not yet completed.
    assign cmp_vld_o     = (cmp_q != dlv_q);
    assign cmp_id_o      = ring_q[cmp_q[IDX_W-1:0]];

    always_comb begin
        push_ok  = push_i && (outstanding_o != PTR_W'(DEPTH));
        dlv_fire = dlv_rdy_i && dlv_vld_o;
        cmp_fire = cmp_pop_i && cmp_vld_o;
        ring_d   = ring_q;
        if (push_ok) begin
            ring_d[wr_q[IDX_W-1:0]] = push_id_i;
        end
        wr_d  = wr_q  + PTR_W'(push_ok);
        dlv_d = dlv_q + PTR_W'(dlv_fire);
        cmp_d = cmp_q + PTR_W'(cmp_fire);
    end

    // Storage is cleared too so dlv_id_o reads 0 straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            wr_q  <= '0;
            dlv_q <= '0;
            cmp_q <= '0;
        end else begin
            ring_q <= ring_d;
            wr_q   <= wr_d;
            dlv_q  <= dlv_d;
            cmp_q  <= cmp_d;
        end
    end

endmodule

// File: rtl/plic_claim_sequencer.sv
// Auto-claim engine for one PLIC target: claims on eip, delivers IDs, writes completes.
// Latency: eip_i -> claim_re_o 1 cycle; claim -> irq_valid_o 1 cycle; done_i -> complete_we_o 1 cycle.
// Backpressure: irq valid/ready holds the ID; claims stall while DEPTH IDs are outstanding.
// Ports: clk_i/rst_i (sync, active-high); en_i/eip_i start claims; claim_re_o/claim_id_i
//        PLIC claim port; irq_valid_o/irq_id_o/irq_ready_i consumer handshake; done_i
//        consumer completion; complete_we_o/complete_id_o PLIC complete port;
//        outstanding_o, spurious_o, err_o status.
module plic_claim_sequencer
    import plic_pkg::*;
#(
    parameter int SRCW    = 5,
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 2,
    parameter int CNT_W   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       eip_i,
    output logic                       claim_re_o,
    input  logic [SRCW-1:0]            claim_id_i,
    output logic                       irq_valid_o,
    output logic [SRCW-1:0]            irq_id_o,
    input  logic                       irq_ready_i,
    input  logic                       done_i,
    output logic                       complete_we_o,
    output logic [SRCW-1:0]            complete_id_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic [CNT_W-1:0]           spurious_o,
    output logic                       err_o
);

    localparam int PTR_W     = ptr_w(DEPTH);
    localparam int HOLD_LAST = (HOLDOFF > 2) ? HOLDOFF - 2 : 0;
    localparam int HC_W      = (HOLDOFF > 2) ? $clog2(HOLDOFF - 1) : 1;

    state_e           state_q, state_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] spurious_q, spurious_d;
    logic             err_q, err_d;
    logic             complete_we_q, complete_we_d;
    logic [SRCW-1:0]  complete_id_q, complete_id_d;

    logic             push;
    logic             cmp_vld;
    logic [SRCW-1:0]  cmp_id;
    logic [PTR_W-1:0] ring_cnt;
    logic             ring_full;

    assign push      = claim_re_o && (claim_id_i != '0);
    assign ring_full = (ring_cnt == PTR_W'(DEPTH));

    plic_id_ring #(
        .SRCW  (SRCW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (push),
        .push_id_i     (claim_id_i),
        .dlv_vld_o     (irq_valid_o),
        .dlv_id_o      (irq_id_o),
        .dlv_rdy_i     (irq_ready_i),
        .cmp_vld_o     (cmp_vld),
        .cmp_id_o      (cmp_id),
        .cmp_pop_i     (done_i),
        .outstanding_o (ring_cnt)
    );

    // State register plus status flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            spurious_q    <= '0;
            err_q         <= 1'b0;
            complete_we_q <= 1'b0;
            complete_id_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            spurious_q    <= spurious_d;
            err_q         <= err_d;
            complete_we_q <= complete_we_d;
            complete_id_q <= complete_id_d;
        end
    end

    // Next state. The IDLE cycle that samples eip_i is itself the last holdoff
    // cycle, so HOLD lasts HOLDOFF-1 cycles and claims are HOLDOFF+1 apart.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (en_i && eip_i && !ring_full) begin
                    state_d = CLAIM;
                end
            end
            CLAIM: begin
                hold_cnt_d = '0;
                state_d    = (HOLDOFF >= 2) ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_cnt_q == HC_W'(HOLD_LAST)) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: claim strobe comes straight from the state register.
    always_comb begin
        claim_re_o = (state_q == CLAIM);
    end

    // Completion, spurious counting and the sticky error flag.
    always_comb begin
        spurious_d    = spurious_q;
        if (claim_re_o && (claim_id_i == '0) && (spurious_q != '1)) begin
            spurious_d = spurious_q + 1'b1;
        end
        complete_we_d = done_i && cmp_vld;
        complete_id_d = complete_we_d ? cmp_id : complete_id_q;
        err_d         = err_q || (done_i && !cmp_vld);
    end

    assign complete_we_o = complete_we_q;
    assign complete_id_o = complete_id_q;
    assign outstanding_o = ring_cnt;
    assign spurious_o    = spurious_q;
    assign err_o         = err_q;

endmodule
